m_memarb: RTL and testbench
===========================

# m_memarb

Two-port arbiter that shares one single-port 4096×32-bit synchronous memory between the pipeline's instruction-fetch (I) port and data-access (D) port, enabling a unified instruction/data memory. Each cycle it grants at most one requester, drives the memory address/write controls, and returns registered read-valid/write-ack strobes one cycle later. D has priority, with a bounded-starvation guarantee for I and a fetch-flush input for taken branches.

## Interface
- P_MAXWAIT, 2: consecutive cycles I may be denied while requesting; after that I wins the next conflict (0 = I always wins).
- w_clk  in  1  clock, all state on rising edge
- w_rst  in  1  reset, asynchronous, active-high
- w_ireq  in  1  I read request
- w_iaddr  in  12  I word address
- w_iflush  in  1  cancel response of the I read granted this cycle
- w_igrant  out  1  I granted this cycle (combinational)
- r_ivalid  out  1  I read data valid on w_idata (registered)
- w_idata  out  32  read data, = w_mdout
- w_dreq  in  1  D request
- w_dwe  in  1  D request is a write
- w_daddr  in  12  D word address
- w_ddin  in  32  D write data
- w_dgrant  out  1  D granted this cycle (combinational)
- r_dvalid  out  1  D read data valid on w_ddata (registered)
- r_dack  out  1  D write completed (registered)
- w_ddata  out  32  read data, = w_mdout
- w_maddr  out  12  memory word address
- w_mwe  out  1  memory write enable
- w_mdin  out  32  memory write data, = w_ddin
- w_mdout  in  32  memory registered read data
- r_conflicts  out  32  cycles in which w_ireq and w_dreq were both high

## Operation
- Grant (combinational, forced 0 while w_rst=1):
  - only D requests → D; only I → I; neither → none.
  - both request → I if r_starve >= P_MAXWAIT, else D.
  - w_igrant and w_dgrant are never both high.
- r_starve (width ceil(log2(P_MAXWAIT+1)), min 1 bit): reset 0; +1 (saturating at P_MAXWAIT) when w_ireq & ~w_igrant; cleared to 0 when w_igrant or ~w_ireq.
- Memory drive: w_maddr = w_dgrant ? w_daddr : w_iaddr (holds I address when idle); w_mwe = w_dgrant & w_dwe; w_mdin = w_ddin unconditionally.
- Response registers (next-edge values):
  - r_ivalid <= w_igrant & ~w_iflush
  - r_dvalid <= w_dgrant & ~w_dwe
  - r_dack <= w_dgrant & w_dwe
- A flushed I grant still occupies the memory slot and still clears r_starve.
- r_conflicts <= r_conflicts + 1 when w_ireq & w_dreq; wraps modulo 2^32; counts regardless of grant outcome.
- Requesters hold request/address/data until granted; an ungranted request has no side effects.

## Timing
- Reset values: r_ivalid=0, r_dvalid=0, r_dack=0, r_conflicts=0, r_starve=0. Combinational outputs while reset is asserted: w_igrant=0, w_dgrant=0, w_mwe=0.
- Asserting w_rst mid-operation (between a grant and its response) clears all strobes immediately. The in-flight response is dropped and not issued after release.
- Grant in cycle t: memory samples the address/write at the end-of-t edge. r_ivalid, r_dvalid or r_dack is high for exactly one cycle, t+1. Read data on w_idata/w_ddata is valid in t+1.
- Throughput: one access per cycle, back-to-back, no bubbles.
- Write in t, then read of the same address in t+1 returns the new data in t+2.
- Under continuous conflict with P_MAXWAIT=N, the grant pattern is N×D then 1×I, repeating. I worst-case wait is N cycles.
- A single cycle can assert r_ivalid or r_dvalid/r_dack, never both.

## Test plan
- Reset release, memory word 5 = 0xA5; w_ireq=1, w_iaddr=5 for 3 cycles → w_igrant high 3 cycles; r_ivalid high on the 3 following cycles with w_idata=0xA5; r_dvalid=r_dack=0.
- P_MAXWAIT=2; w_ireq=w_dreq=1 (D reads) held 6 cycles → grants D,D,I,D,D,I; r_dvalid 4 pulses, r_ivalid 2 pulses; r_conflicts=6.
- D write addr 9 data 0x00001234 in cycle t; I read addr 9 in t+1 → r_dack at t+1; r_ivalid at t+2 with w_idata=0x00001234; w_mwe high only in t.
- I granted with w_iflush=1 → no r_ivalid next cycle; r_starve=0. Following unflushed grant → r_ivalid next cycle.
- I granted at t; w_rst pulsed asynchronously mid-t+1 before the edge → r_ivalid drops to 0 at once; r_conflicts=0; no strobe after release until a new grant.
- P_MAXWAIT=0; simultaneous requests for 3 cycles → w_igrant every cycle, w_dgrant never; the following D-only cycle → w_dgrant=1.

Source files
------------

// File: rtl/m_memarb.sv
// Unified I/D memory arbiter: one single-port synchronous memory shared by
// instruction fetch and data access, D-priority with bounded I starvation.
module m_memarb #(
  parameter int unsigned P_MAXWAIT = 2
) (
  input  logic        w_clk,
  input  logic        w_rst,
  // instruction-fetch port
  input  logic        w_ireq,
  input  logic [11:0] w_iaddr,
  input  logic        w_iflush,
  output logic        w_igrant,
  output logic        r_ivalid,
  output logic [31:0] w_idata,
  // data-access port
  input  logic        w_dreq,
  input  logic        w_dwe,
  input  logic [11:0] w_daddr,
  input  logic [31:0] w_ddin,
  output logic        w_dgrant,
  output logic        r_dvalid,
  output logic        r_dack,
  output logic [31:0] w_ddata,
  // memory side
  output logic [11:0] w_maddr,
  output logic        w_mwe,
  output logic [31:0] w_mdin,
  input  logic [31:0] w_mdout,
  // statistics
  output logic [31:0] r_conflicts
);

  localparam int unsigned SW =
    (P_MAXWAIT < 2) ? 1 : $clog2(P_MAXWAIT + 1);
  localparam logic [SW-1:0] MAXW = SW'(P_MAXWAIT);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic [31:0]   conflicts_d;
  logic          ivalid_d;
  logic          dvalid_d;
  logic          dack_d;
  logic          i_wins;
  logic          both_req;

  // I takes a conflicting cycle once it has been denied long enough
  assign i_wins   = (starve_q >= MAXW);
  assign both_req = w_ireq & w_dreq;

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    w_dgrant = 1'b0;
    w_igrant = 1'b0;
    if (!w_rst) begin
      if (both_req) begin
        w_igrant = i_wins;
        w_dgrant = ~i_wins;
      end else begin
        w_igrant = w_ireq;
        w_dgrant = w_dreq;
      end
    end
  end

  // Memory drive: idle cycles keep the fetch address on the bus
  always_comb begin
    w_maddr = w_dgrant ? w_daddr : w_iaddr;
    w_mwe   = w_dgrant & w_dwe;
    w_mdin  = w_ddin;
    w_idata = w_mdout;
    w_ddata = w_mdout;
  end

  // Next-state for starvation counter, response strobes and statistics
  always_comb begin
    starve_d = '0;
    if (w_ireq & ~w_igrant) begin
      if (starve_q == MAXW) starve_d = starve_q;
      else                  starve_d = starve_q + SW'(1);
    end
    conflicts_d = r_conflicts;
    if (both_req) conflicts_d = r_conflicts + 32'd1;
    ivalid_d = w_igrant & ~w_iflush;
    dvalid_d = w_dgrant & ~w_dwe;
    dack_d   = w_dgrant & w_dwe;
  end

  // State registers; reset drops any in-flight response immediately
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      starve_q    <= '0;
      r_conflicts <= '0;
      r_ivalid    <= 1'b0;
      r_dvalid    <= 1'b0;
      r_dack      <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      r_conflicts <= conflicts_d;
      r_ivalid    <= ivalid_d;
      r_dvalid    <= dvalid_d;
      r_dack      <= dack_d;
    end
  end

endmodule

// File: tb/tb_m_memarb.sv
// Scoreboard bench for m_memarb: a queue-based reference model predicts
// grants and responses; a negedge monitor pops and compares.
module tb_m_memarb;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, iflush, dreq, dwe;
  logic [11:0] iaddr, daddr;
  logic [31:0] ddin;
  logic        igrant, ivalid, dgrant, dvalid, dack, mwe;
  logic [31:0] idata, ddata, mdin, mdout, conf;
  logic [11:0] maddr;

  logic        igrant0, ivalid0, dgrant0, dvalid0, dack0, mwe0;
  logic [31:0] idata0, ddata0, mdin0, conf0;
  logic [31:0] mdout0 = 32'h0;
  logic [11:0] maddr0;

  always #5 clk = ~clk;

  m_memarb #(.P_MAXWAIT(N)) u_dut (
    .w_clk(clk), .w_rst(rst),
    .w_ireq(ireq), .w_iaddr(iaddr), .w_iflush(iflush),
    .w_igrant(igrant), .r_ivalid(ivalid), .w_idata(idata),
    .w_dreq(dreq), .w_dwe(dwe), .w_daddr(daddr), .w_ddin(ddin),
    .w_dgrant(dgrant), .r_dvalid(dvalid), .r_dack(dack),
    .w_ddata(ddata),
    .w_maddr(maddr), .w_mwe(mwe), .w_mdin(mdin), .w_mdout(mdout),
    .r_conflicts(conf)
  );

  m_memarb #(.P_MAXWAIT(0)) u_dut0 (
    .w_clk(clk), .w_rst(rst),
    .w_ireq(ireq), .w_iaddr(iaddr), .w_iflush(iflush),
    .w_igrant(igrant0), .r_ivalid(ivalid0), .w_idata(idata0),
    .w_dreq(dreq), .w_dwe(dwe), .w_daddr(daddr), .w_ddin(ddin),
    .w_dgrant(dgrant0), .r_dvalid(dvalid0), .r_dack(dack0),
    .w_ddata(ddata0),
    .w_maddr(maddr0), .w_mwe(mwe0), .w_mdin(mdin0), .w_mdout(mdout0),
    .r_conflicts(conf0)
  );

  // Synchronous read-first memory behind the main instance
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (mwe) mem[maddr] <= mdin;
    mdout <= mem[maddr];
  end

  // Reference model state
  typedef struct {
    int          cyc;
    logic [2:0]  strb;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] ref_mem [4096];
  int          cyc     = 0;
  int          denied  = 0;
  int          m_conf  = 0;
  logic        m_ig, m_dg;
  logic        last_ig, last_dg0;
  int          n_chk   = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus plus model prediction
  task automatic step(input logic ir, input logic [11:0] ia,
                      input logic fl, input logic dr, input logic we,
                      input logic [11:0] da, input logic [31:0] dd);
    logic eig, edg, eig0, edg0;
    ireq = ir; iaddr = ia; iflush = fl;
    dreq = dr; dwe = we; daddr = da; ddin = dd;
    #2;
    eig = 0; edg = 0; eig0 = 0; edg0 = 0;
    if (!rst) begin
      if (ir && dr) begin
        eig = (denied >= N);
        edg = !eig;
      end else begin
        eig = ir;
        edg = dr;
      end
      eig0 = ir;
      edg0 = dr && !ir;
    end
    m_ig = eig; m_dg = edg;
    chk("igrant", igrant, eig);
    chk("dgrant", dgrant, edg);
    chk("maddr", maddr, edg ? da : ia);
    chk("mwe", mwe, edg && we);
    chk("mdin", mdin, dd);
    chk("igrant_n0", igrant0, eig0);
    chk("dgrant_n0", dgrant0, edg0);
    last_ig  = igrant;
    last_dg0 = dgrant0;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (eig && !fl) q.push_back('{cyc, 3'b100, ref_mem[ia]});
      if (edg) begin
        if (we) begin
          q.push_back('{cyc, 3'b001, 32'h0});
          ref_mem[da] = dd;
        end else begin
          q.push_back('{cyc, 3'b010, ref_mem[da]});
        end
      end
      if (ir && !eig) denied = (denied < N) ? denied + 1 : N;
      else            denied = 0;
      if (ir && dr) m_conf++;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 12'd0, 0, 0, 0, 12'd0, 32'h0);
  endtask

  // Monitor: compare every presented strobe against the queue head
  always @(negedge clk) begin
    rsp_t e;
    chk("conflicts", conf, m_conf);
    chk("conflicts_n0", conf0, m_conf);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missed_rsp: got none expected strb %b @cyc %0d",
               e.strb, e.cyc);
    end
    if (ivalid || dvalid || dack) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_rsp: got strb %b expected none @cyc %0d",
                 {ivalid, dvalid, dack}, cyc);
      end else begin
        e = q.pop_front();
        chk("rsp_cyc", cyc, e.cyc);
        chk("rsp_strb", {ivalid, dvalid, dack}, e.strb);
        if (e.strb[2]) chk("idata", idata, e.data);
        if (e.strb[1]) chk("ddata", ddata, e.data);
      end
    end
  end

  initial begin
    logic       ir, dr, we, fl;
    logic [11:0] ia, da;
    logic [31:0] dd;
    logic       hold_i, hold_d;
    logic [5:0] pat;

    for (int a = 0; a < 4096; a++) begin
      mem[a]     = 32'hC0DE_0000 | a;
      ref_mem[a] = 32'hC0DE_0000 | a;
    end
    mem[5]     = 32'h0000_00A5;
    ref_mem[5] = 32'h0000_00A5;

    // Reset state with requests pending
    rst = 1'b1;
    ireq = 1; iaddr = 5; iflush = 0;
    dreq = 1; dwe = 1; daddr = 3; ddin = 32'hDEAD;
    #3;
    chk("rst_igrant", igrant, 0);
    chk("rst_dgrant", dgrant, 0);
    chk("rst_mwe", mwe, 0);
    chk("rst_strb", {ivalid, dvalid, dack}, 0);
    chk("rst_conf", conf, 0);
    step(1, 12'd5, 0, 1, 1, 12'd3, 32'hDEAD);
    step(1, 12'd5, 0, 1, 0, 12'd3, 32'hDEAD);
    rst = 1'b0;

    // Three back-to-back I reads of word 5
    repeat (3) step(1, 12'd5, 0, 0, 0, 12'd0, 32'h0);
    idle();

    // Continuous conflict: D,D,I,D,D,I
    for (int k = 0; k < 6; k++) begin
      step(1, 12'd40, 0, 1, 0, 12'd20, 32'h0);
      pat[k] = last_ig;
    end
    chk("grant_pattern", pat, 6'b100100);
    chk("conflicts6", conf, 6);
    idle();

    // Write then read-after-write on the other port
    step(0, 12'd0, 0, 1, 1, 12'd9, 32'h0000_1234);
    step(1, 12'd9, 0, 0, 0, 12'd0, 32'h0);
    idle();

    // Flushed grant clears starvation; unflushed one responds
    step(1, 12'd7, 0, 1, 0, 12'd30, 32'h0);
    step(1, 12'd7, 1, 0, 0, 12'd0, 32'h0);
    step(1, 12'd8, 0, 0, 0, 12'd0, 32'h0);
    repeat (3) step(1, 12'd11, 0, 1, 0, 12'd31, 32'h0);
    idle();

    // P_MAXWAIT=0 instance: I always wins, then D alone
    repeat (3) step(1, 12'd12, 0, 1, 1, 12'd13, 32'h55);
    step(0, 12'd0, 0, 1, 0, 12'd13, 32'h0);
    chk("n0_donly", last_dg0, 1);

    // Reset between a grant and its response
    step(1, 12'd5, 0, 0, 0, 12'd0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ivalid", ivalid, 0);
    chk("midrst_conf", conf, 0);
    chk("midrst_igrant", igrant, 0);
    q.delete();
    denied = 0;
    m_conf = 0;
    step(1, 12'd5, 0, 1, 0, 12'd6, 32'h0);
    step(1, 12'd5, 0, 1, 0, 12'd6, 32'h0);
    rst = 1'b0;
    repeat (3) idle();
    step(1, 12'd5, 0, 0, 0, 12'd0, 32'h0);
    idle();

    // Randomized traffic honouring hold-until-granted
    hold_i = 0; hold_d = 0;
    ir = 0; ia = 0; dr = 0; we = 0; da = 0; dd = 0;
    for (int k = 0; k < 400; k++) begin
      if (!hold_i) begin
        ir = ($urandom_range(0, 9) < 6);
        ia = 12'($urandom_range(0, 15));
      end
      if (!hold_d) begin
        dr = ($urandom_range(0, 9) < 5);
        we = $urandom_range(0, 1);
        da = 12'($urandom_range(0, 15));
        dd = $urandom;
      end
      fl = ($urandom_range(0, 3) == 0);
      step(ir, ia, fl, dr, we, da, dd);
      hold_i = ir && !m_ig;
      hold_d = dr && !m_dg;
    end
    repeat (2) idle();
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
